// File: rtl/way_select_pipe_if.sv
// Request/response bundle between the tag array read, way_select_pipe and the cache controller.
interface way_select_pipe_if #(
  parameter int WAYS      = 4,
  parameter int TAG_WIDTH = 14,
  parameter int SETS      = 16,
  parameter int IDX_W     = $clog2(SETS)
);
  logic                      req_valid;
  logic [IDX_W-1:0]          req_index;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic                      req_alloc;
  logic [WAYS*TAG_WIDTH-1:0] way_tags;
  logic [WAYS-1:0]           way_valid;
  logic [WAYS-1:0]           way_dirty;
  logic                      flush_req;
  logic                      req_ready;
  logic                      rsp_valid;
  logic                      rsp_hit;
  logic [WAYS-1:0]           rsp_hit_way;
  logic                      rsp_multi_hit;
  logic [WAYS-1:0]           rsp_victim_way;
  logic                      rsp_victim_dirty;
  logic                      flush_busy;

  modport master (
    output req_valid, req_index, req_tag, req_alloc, way_tags, way_valid, way_dirty, flush_req,
    input  req_ready, rsp_valid, rsp_hit, rsp_hit_way, rsp_multi_hit, rsp_victim_way,
           rsp_victim_dirty, flush_busy
  );
  modport slave (
    input  req_valid, req_index, req_tag, req_alloc, way_tags, way_valid, way_dirty, flush_req,
    output req_ready, rsp_valid, rsp_hit, rsp_hit_way, rsp_multi_hit, rsp_victim_way,
           rsp_victim_dirty, flush_busy
  );
endinterface

// File: rtl/way_select_pipe.sv
// Registered WAYS-way tag compare / victim select owning per-set tree-PLRU state,
// with same-set bypass and a sequenced PLRU flush walk.
module way_tag_cmp #(
  parameter int TAG_WIDTH = 14
) (
  input  logic [TAG_WIDTH-1:0] tag,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 vld,
  input  logic                 req_vld,
  output logic                 hit
);
  assign hit = req_vld & vld & (tag == req_tag);
endmodule

module way_select_pipe #(
  parameter int WAYS      = 4,
  parameter int TAG_WIDTH = 14,
  parameter int SETS      = 16
) (
  input  logic           clk,
  input  logic           reset,
  way_select_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int NODES = WAYS - 1;
  localparam int LVLS  = $clog2(WAYS);

  typedef enum logic {IDLE, WALK} state_e;

  // Path bits of w, MSB first, pick lower(0)/upper(1) child; each node points away from w.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] cur,
                                                  input logic [LVLS-1:0] w);
    logic [NODES-1:0] r;
    int n;
    r = cur;
    n = 0;
    for (int l = 0; l < LVLS; l++) begin
      r[n] = w[LVLS-1-l];
      n    = 2*n + 1 + (w[LVLS-1-l] ? 1 : 0);
    end
    return r;
  endfunction

  // Node bit 0 steers toward the upper child, 1 toward the lower child.
  function automatic logic [LVLS-1:0] plru_victim(input logic [NODES-1:0] p);
    int n;
    n = 0;
    for (int l = 0; l < LVLS; l++)
      n = 2*n + 1 + (p[n] ? 0 : 1);
    return LVLS'(n - NODES);
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [NODES-1:0]   plru_q [SETS];
  logic [NODES-1:0]   plru_d [SETS];

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_multi_q, rsp_multi_d;
  logic [WAYS-1:0]    rsp_hit_way_q, rsp_hit_way_d;
  logic [WAYS-1:0]    rsp_vic_way_q, rsp_vic_way_d;
  logic               rsp_vic_dirty_q, rsp_vic_dirty_d;
  logic [LVLS-1:0]    rsp_hit_idx_q, rsp_hit_idx_d;
  logic [LVLS-1:0]    rsp_vic_idx_q, rsp_vic_idx_d;
  logic [IDX_W-1:0]   rsp_index_q, rsp_index_d;
  logic               rsp_alloc_q, rsp_alloc_d;

  logic               walking, accept, plru_we;
  logic [WAYS-1:0]    hit_vec;
  logic               hit_any, multi, inv_any;
  logic [LVLS-1:0]    hit_idx, inv_idx, vic_idx;
  logic [NODES-1:0]   plru_upd, plru_rd;

  assign walking = (state_q == WALK);
  assign accept  = bus.req_valid & ~walking;

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    way_tag_cmp #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
      .tag     (bus.way_tags[w*TAG_WIDTH +: TAG_WIDTH]),
      .req_tag (bus.req_tag),
      .vld     (bus.way_valid[w]),
      .req_vld (bus.req_valid),
      .hit     (hit_vec[w])
    );
  end

  // Flush clear outranks the write-back of a response still in flight.
  assign plru_we  = rsp_valid_q & (rsp_hit_q | rsp_alloc_q) & ~walking;
  assign plru_upd = plru_touch(plru_q[rsp_index_q], rsp_hit_q ? rsp_hit_idx_q : rsp_vic_idx_q);
  assign plru_rd  = (plru_we && rsp_index_q == bus.req_index) ? plru_upd : plru_q[bus.req_index];

  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    inv_any = 1'b0;
    for (int w = WAYS-1; w >= 0; w--)
      if (hit_vec[w]) hit_idx = LVLS'(w);
    for (int w = 0; w < WAYS; w++)
      if (!bus.way_valid[w]) begin
        inv_idx = LVLS'(w);
        inv_any = 1'b1;
      end
    hit_any = |hit_vec;
    multi   = |(hit_vec & (hit_vec - WAYS'(1)));
    vic_idx = inv_any ? inv_idx : plru_victim(plru_rd);
  end

  always_comb begin
    rsp_valid_d     = accept;
    rsp_hit_d       = 1'b0;
    rsp_multi_d     = 1'b0;
    rsp_hit_way_d   = '0;
    rsp_vic_way_d   = '0;
    rsp_vic_dirty_d = 1'b0;
    rsp_hit_idx_d   = '0;
    rsp_vic_idx_d   = '0;
    rsp_index_d     = '0;
    rsp_alloc_d     = 1'b0;
    if (accept) begin
      rsp_hit_d       = hit_any;
      rsp_multi_d     = multi;
      rsp_hit_way_d   = hit_any ? (WAYS'(1) << hit_idx) : '0;
      rsp_vic_way_d   = WAYS'(1) << vic_idx;
      rsp_vic_dirty_d = ~hit_any & ~inv_any & bus.way_dirty[vic_idx];
      rsp_hit_idx_d   = hit_idx;
      rsp_vic_idx_d   = vic_idx;
      rsp_index_d     = bus.req_index;
      rsp_alloc_d     = bus.req_alloc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.flush_req) begin
        state_d = WALK;
        cnt_d   = '0;
      end
      WALK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    plru_d = plru_q;
    if (walking)      plru_d[cnt_q]       = '0;
    else if (plru_we) plru_d[rsp_index_q] = plru_upd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_multi_q     <= 1'b0;
      rsp_hit_way_q   <= '0;
      rsp_vic_way_q   <= '0;
      rsp_vic_dirty_q <= 1'b0;
      rsp_hit_idx_q   <= '0;
      rsp_vic_idx_q   <= '0;
      rsp_index_q     <= '0;
      rsp_alloc_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      plru_q          <= plru_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_multi_q     <= rsp_multi_d;
      rsp_hit_way_q   <= rsp_hit_way_d;
      rsp_vic_way_q   <= rsp_vic_way_d;
      rsp_vic_dirty_q <= rsp_vic_dirty_d;
      rsp_hit_idx_q   <= rsp_hit_idx_d;
      rsp_vic_idx_q   <= rsp_vic_idx_d;
      rsp_index_q     <= rsp_index_d;
      rsp_alloc_q     <= rsp_alloc_d;
    end
  end

  assign bus.req_ready        = ~walking;
  assign bus.flush_busy       = walking;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_hit          = rsp_hit_q;
  assign bus.rsp_multi_hit    = rsp_multi_q;
  assign bus.rsp_hit_way      = rsp_hit_way_q;
  assign bus.rsp_victim_way   = rsp_vic_way_q;
  assign bus.rsp_victim_dirty = rsp_vic_dirty_q;
endmodule

// File: tb/tb_way_select_pipe.sv
// Scoreboard bench for way_select_pipe (WAYS=4, TAG_WIDTH=14, SETS=16) with a
// table-driven 4-way PLRU reference model.
module tb_way_select_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  way_select_pipe_if #(.WAYS(4), .TAG_WIDTH(14), .SETS(16)) bus ();
  way_select_pipe #(.WAYS(4), .TAG_WIDTH(14), .SETS(16)) dut (.clk(clk), .reset(rst), .bus(bus));

  typedef struct packed {
    logic       hit;
    logic [3:0] hw;
    logic       multi;
    logic [3:0] vw;
    logic       vd;
  } exp_t;

  exp_t       sb [$];
  logic [2:0] m_plru [16];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference tree-PLRU for 4 ways: bit0 root, bit1 covers ways 0/1, bit2 covers ways 2/3.
  function automatic int m_victim(input logic [2:0] p);
    if (!p[0]) return p[2] ? 2 : 3;
    return p[1] ? 0 : 1;
  endfunction

  function automatic logic [2:0] m_touch(input logic [2:0] p, input int w);
    logic [2:0] r;
    r = p;
    case (w)
      0: begin r[0] = 1'b0; r[1] = 1'b0; end
      1: begin r[0] = 1'b0; r[1] = 1'b1; end
      2: begin r[0] = 1'b1; r[2] = 1'b0; end
      default: begin r[0] = 1'b1; r[2] = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 16; s++) m_plru[s] = '0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] idx, input logic [13:0] rtag, input logic [55:0] tags,
                        input logic [3:0] vld, input logic [3:0] dirty, input logic alloc);
    exp_t e;
    logic [3:0] hv;
    int hi, vi;
    logic inv;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.req_tag   = rtag;
    bus.req_alloc = alloc;
    bus.way_tags  = tags;
    bus.way_valid = vld;
    bus.way_dirty = dirty;
    for (int w = 0; w < 4; w++) hv[w] = vld[w] && (tags[w*14 +: 14] == rtag);
    hi = 0;
    for (int w = 3; w >= 0; w--) if (hv[w]) hi = w;
    vi = -1;
    for (int w = 0; w < 4; w++) if (!vld[w]) vi = w;
    inv = (vi >= 0);
    if (!inv) vi = m_victim(m_plru[idx]);
    e.hit   = |hv;
    e.hw    = e.hit ? 4'(1 << hi) : 4'b0;
    e.multi = ($countones(hv) > 1);
    e.vw    = 4'(1 << vi);
    e.vd    = !e.hit && !inv && dirty[vi];
    sb.push_back(e);
    if (e.hit)      m_plru[idx] = m_touch(m_plru[idx], hi);
    else if (alloc) m_plru[idx] = m_touch(m_plru[idx], vi);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) chk("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_hit",      32'(bus.rsp_hit),          32'(e.hit));
          chk("rsp_hit_way",  32'(bus.rsp_hit_way),      32'(e.hw));
          chk("rsp_multi",    32'(bus.rsp_multi_hit),    32'(e.multi));
          chk("rsp_vic_way",  32'(bus.rsp_victim_way),   32'(e.vw));
          chk("rsp_vic_dirty",32'(bus.rsp_victim_dirty), 32'(e.vd));
        end
      end
    end
  end

  localparam logic [55:0] TAGS = {14'h103, 14'h102, 14'h101, 14'h100};

  initial begin
    int busy_cnt;
    logic [55:0] rt;
    bus.req_valid = 0; bus.req_index = 0; bus.req_tag = 0; bus.req_alloc = 0;
    bus.way_tags = 0; bus.way_valid = 0; bus.way_dirty = 0; bus.flush_req = 0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(bus.req_ready),      32'd1);
    chk("rst_valid",   32'(bus.rsp_valid),      32'd0);
    chk("rst_busy",    32'(bus.flush_busy),     32'd0);
    chk("rst_hit_way", 32'(bus.rsp_hit_way),    32'd0);
    chk("rst_vic_way", 32'(bus.rsp_victim_way), 32'd0);
    rst = 1'b0;

    // hit on way 2 at index 5, then a plain miss shows PLRU[5]=001 -> way1
    do_req(4'd5, 14'h102, TAGS, 4'b1111, 4'b0000, 1'b0);
    do_req(4'd5, 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b0);
    // invalid-way victim
    do_req(4'd6, 14'h3ff, TAGS, 4'b1011, 4'b1111, 1'b0);
    // PLRU victim after reset, dirty; then alloc; then next victim
    do_req(4'd7, 14'h3ff, TAGS, 4'b1111, 4'b1000, 1'b0);
    do_req(4'd7, 14'h3ff, TAGS, 4'b1111, 4'b1000, 1'b1);
    do_req(4'd7, 14'h3ff, TAGS, 4'b1111, 4'b0010, 1'b0);
    idle();
    // bypass: back-to-back allocating misses to one set
    for (int i = 0; i < 4; i++) do_req(4'd3, 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b1);
    // multi-hit on ways 1 and 3
    do_req(4'd2, 14'h055, {14'h055, 14'h100, 14'h055, 14'h101}, 4'b1111, 4'b0000, 1'b0);
    // random mix over a small tag/index space
    for (int i = 0; i < 40; i++) begin
      rt = {14'($urandom_range(3)), 14'($urandom_range(3)), 14'($urandom_range(3)), 14'($urandom_range(3))};
      do_req(4'($urandom_range(3)), 14'($urandom_range(3)), rt, 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) idle();
    end
    idle();
    for (int s = 8; s < 12; s++) do_req(4'(s), 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b1);

    // flush with a request in flight; requests and flush_req during walk are ignored
    do_req(4'd8, 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b1);
    bus.flush_req = 1'b1;
    idle();
    busy_cnt = 0;
    chk("flush_ready", 32'(bus.req_ready), 32'd0);
    while (bus.flush_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
      bus.req_valid = (busy_cnt == 3);
      bus.flush_req = (busy_cnt == 5);
    end
    bus.req_valid = 1'b0;
    bus.flush_req = 1'b0;
    chk("flush_len", 32'(busy_cnt), 32'd16);
    m_clear();
    for (int s = 0; s < 16; s++) do_req(4'(s), 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b0);
    idle();

    // reset mid-walk aborts and clears sets the walk had not reached
    do_req(4'd9, 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b1);
    idle();
    idle();
    bus.flush_req = 1'b1;
    idle();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_busy", 32'(bus.flush_busy), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    do_req(4'd9, 14'h3ff, TAGS, 4'b1111, 4'b0000, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
